// File: rtl/y_unload_if.sv
// Bus bundle for y_unload_buffer: PE-side capture handshake, serialized
// output stream and status flags. The slave modport is the buffer's view.
// Optional feature macro: Y_PARITY_EN adds out_parity to the bundle.
interface y_unload_if #(
  parameter int RES_W = 16
);
  logic             res_valid;
  logic [RES_W-1:0] res_lane0;
  logic [RES_W-1:0] res_lane1;
  logic [RES_W-1:0] res_lane2;
  logic [RES_W-1:0] res_lane3;
  logic             cap_ready;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_data;
  logic             out_last;
  logic             unload_done;
  logic             res_overrun;
`ifdef Y_PARITY_EN
  logic             out_parity;
`endif

  modport master (
    output res_valid, res_lane0, res_lane1, res_lane2, res_lane3, out_ready,
    input  cap_ready, out_valid, out_data, out_last, unload_done, res_overrun
`ifdef Y_PARITY_EN
    , input out_parity
`endif
  );

  modport slave (
    input  res_valid, res_lane0, res_lane1, res_lane2, res_lane3, out_ready,
    output cap_ready, out_valid, out_data, out_last, unload_done, res_overrun
`ifdef Y_PARITY_EN
    , output out_parity
`endif
  );
endinterface

// File: rtl/y_unload_buffer.sv
// y_unload_buffer: captures DEPTH result elements from each of the 4 PE lanes
// into lane shift registers, then streams all 4*DEPTH words out one at a time,
// lane-interleaved (lane0..lane3 of element 0, then element 1, ...).
// Optional feature macro: Y_PARITY_EN drives bus.out_parity = ^out_data while
// a word is valid, 0 otherwise.
module y_unload_buffer #(
  parameter int RES_W = 16,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  y_unload_if.slave   bus
);

  localparam int LW = DEPTH * RES_W;
  localparam int CW = $clog2(DEPTH);
  localparam int OW = $clog2(4 * DEPTH);
  localparam logic [CW-1:0] CAP_LAST = CW'(DEPTH - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(4 * DEPTH - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DRAIN   = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lane_q [4];
  logic [LW-1:0] lane_d [4];
  logic [CW-1:0] cap_cnt_q, cap_cnt_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic          ovr_q, ovr_d;

  logic [1:0]       sel;
  logic             cap_ready_c;
  logic             out_valid_c;
  logic             out_last_c;
  logic             done_c;
  logic [RES_W-1:0] out_data_c;

  // The low two bits of the output index pick the lane; the element order
  // falls out of the per-lane left shifts.
  assign sel = out_cnt_q[1:0];

  // Next-state, counter, lane shift and output decode for the unload FSM.
  always_comb begin
    state_d     = state_q;
    cap_cnt_d   = cap_cnt_q;
    out_cnt_d   = out_cnt_q;
    ovr_d       = ovr_q;
    for (int i = 0; i < 4; i++) lane_d[i] = lane_q[i];
    cap_ready_c = 1'b0;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    done_c      = 1'b0;
    out_data_c  = '0;

    case (state_q)
      S_COLLECT: begin
        cap_ready_c = 1'b1;
        if (bus.res_valid) begin
          // Shift in at the LSB so the first element ends up in the MSB word.
          lane_d[0] = {lane_q[0][LW-RES_W-1:0], bus.res_lane0};
          lane_d[1] = {lane_q[1][LW-RES_W-1:0], bus.res_lane1};
          lane_d[2] = {lane_q[2][LW-RES_W-1:0], bus.res_lane2};
          lane_d[3] = {lane_q[3][LW-RES_W-1:0], bus.res_lane3};
          if (cap_cnt_q == CAP_LAST) begin
            cap_cnt_d = '0;
            state_d   = S_DRAIN;
          end else begin
            cap_cnt_d = cap_cnt_q + CW'(1);
          end
        end
      end

      S_DRAIN: begin
        out_valid_c = 1'b1;
        out_data_c  = lane_q[sel][LW-1 -: RES_W];
        out_last_c  = (out_cnt_q == OUT_LAST);
        if (bus.res_valid) ovr_d = 1'b1;
        if (bus.out_ready) begin
          // Only the lane that just supplied a word advances.
          lane_d[sel] = lane_q[sel] << RES_W;
          if (out_cnt_q == OUT_LAST) begin
            out_cnt_d = '0;
            state_d   = S_DONE;
          end else begin
            out_cnt_d = out_cnt_q + OW'(1);
          end
        end
      end

      S_DONE: begin
        done_c  = 1'b1;
        if (bus.res_valid) ovr_d = 1'b1;
        state_d = S_COLLECT;
      end

      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  // State register; reset also clears captured data so a partial drain is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_COLLECT;
      cap_cnt_q <= '0;
      out_cnt_q <= '0;
      ovr_q     <= 1'b0;
      for (int i = 0; i < 4; i++) lane_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cap_cnt_q <= cap_cnt_d;
      out_cnt_q <= out_cnt_d;
      ovr_q     <= ovr_d;
      for (int i = 0; i < 4; i++) lane_q[i] <= lane_d[i];
    end
  end

  assign bus.cap_ready   = cap_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_data    = out_data_c;
  assign bus.out_last    = out_last_c;
  assign bus.unload_done = done_c;
  assign bus.res_overrun = ovr_q;

`ifdef Y_PARITY_EN
  // out_data_c is already zero outside DRAIN, so parity is 0 there as well.
  assign bus.out_parity = ^out_data_c;
`endif

endmodule

// File: tb/tb_y_unload_buffer.sv
// Self-checking bench for y_unload_buffer (RES_W=16, DEPTH=8): directed
// scenarios plus random traffic against a queue-based reference model.
module tb_y_unload_buffer;
  localparam int RES_W = 16;
  localparam int DEPTH = 8;
  localparam int NW    = 4 * DEPTH;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  y_unload_if #(.RES_W(RES_W)) bus ();

  y_unload_buffer #(.RES_W(RES_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (sampled on falling edge) ----------------
  logic [4*RES_W-1:0] elem_buf [$];   // captured elements, lane n at [n*RES_W +: RES_W]
  logic [RES_W-1:0]   exp_q    [$];   // words still owed on the output stream
  logic [RES_W-1:0]   seen_q   [$];   // words actually handed off
  int                 last_cnt = 0;
  int                 hs_total = 0;
  bit                 done_m   = 0;
  bit                 ovr_m    = 0;
  bit                 known    = 0;

  always @(negedge clk) begin
    bit in_drain, in_coll, done_next;
    in_drain  = (exp_q.size() > 0);
    in_coll   = !in_drain && !done_m;
    done_next = 0;
    if (known) begin
      chk("out_valid",   bus.out_valid,   in_drain);
      chk("cap_ready",   bus.cap_ready,   in_coll);
      chk("unload_done", bus.unload_done, done_m);
      chk("res_overrun", bus.res_overrun, ovr_m);
      if (in_drain) begin
        chk("out_data", bus.out_data, exp_q[0]);
        chk("out_last", bus.out_last, exp_q.size() == 1);
`ifdef Y_PARITY_EN
        chk("out_parity", bus.out_parity, $countones(exp_q[0]) % 2);
`endif
      end else begin
        chk("out_last_idle", bus.out_last, 0);
`ifdef Y_PARITY_EN
        chk("out_parity_idle", bus.out_parity, 0);
`endif
      end
    end
    if (!rst) begin
      elem_buf.delete();
      exp_q.delete();
      done_m = 0;
      ovr_m  = 0;
      known  = 1;
    end else if (known) begin
      if (bus.res_valid) begin
        if (in_coll) begin
          elem_buf.push_back({bus.res_lane3, bus.res_lane2, bus.res_lane1, bus.res_lane0});
          if (elem_buf.size() == DEPTH) begin
            for (int e = 0; e < DEPTH; e++)
              for (int n = 0; n < 4; n++)
                exp_q.push_back(elem_buf[e][n*RES_W +: RES_W]);
            elem_buf.delete();
          end
        end else begin
          ovr_m = 1;
        end
      end
      if (in_drain && bus.out_ready) begin
        seen_q.push_back(exp_q[0]);
        if (exp_q.size() == 1) last_cnt++;
        void'(exp_q.pop_front());
        hs_total++;
        if (exp_q.size() == 0) done_next = 1;
      end
      done_m = done_next;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [RES_W-1:0] a, b, c, d);
    bus.res_lane0 = a;
    bus.res_lane1 = b;
    bus.res_lane2 = c;
    bus.res_lane3 = d;
  endtask

  task automatic capture_random();
    for (int e = 0; e < DEPTH; e++) begin
      bus.res_valid = 1'b1;
      set_lanes(RES_W'($urandom), RES_W'($urandom), RES_W'($urandom), RES_W'($urandom));
      step();
    end
    bus.res_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound, input bit bp);
    int n = 0;
    while (!bus.unload_done && n < bound) begin
      if (bp) bus.out_ready = (n % 3 == 0);
      step();
      n++;
    end
    checks++;
    if (!bus.unload_done) begin
      failures++;
      $display("FAIL %s timeout got=%0d want=unload_done", name, n);
    end
    bus.out_ready = 1'b1;
  endtask

  initial begin
    int start, n;
    rst = 1'b0;
    bus.res_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_lanes('0, '0, '0, '0);

    // Reset held two cycles
    step();
    step();
    chk("rst_out_valid",   bus.out_valid,   0);
    chk("rst_cap_ready",   bus.cap_ready,   1);
    chk("rst_res_overrun", bus.res_overrun, 0);
    chk("rst_unload_done", bus.unload_done, 0);
    rst = 1'b1;
    step();

    // Directed pattern lane n elem e = 16'h(n)(e)00, no backpressure
    seen_q.delete();
    last_cnt = 0;
    bus.out_ready = 1'b1;
    for (int e = 0; e < DEPTH; e++) begin
      bus.res_valid = 1'b1;
      set_lanes({4'h0, 4'(e), 8'h00}, {4'h1, 4'(e), 8'h00},
                {4'h2, 4'(e), 8'h00}, {4'h3, 4'(e), 8'h00});
      step();
    end
    bus.res_valid = 1'b0;
    chk("first_word_valid", bus.out_valid, 1);
    wait_done("pattern_done", 100, 0);
    chk("pattern_count", seen_q.size(), NW);
    if (seen_q.size() == NW) begin
      chk("word0",  seen_q[0],  16'h0000);
      chk("word1",  seen_q[1],  16'h1000);
      chk("word3",  seen_q[3],  16'h3000);
      chk("word4",  seen_q[4],  16'h0100);
      chk("word5",  seen_q[5],  16'h1100);
      chk("word31", seen_q[31], 16'h3700);
    end
    chk("last_count", last_cnt, 1);
    step();
    chk("cap_ready_after", bus.cap_ready, 1);

    // Backpressure: out_ready 1,0,0 repeating
    seen_q.delete();
    capture_random();
    wait_done("bp_done", 300, 1);
    chk("bp_count", seen_q.size(), NW);
    step();

    // Overrun during drain
    chk("ovr_clear_before", bus.res_overrun, 0);
    capture_random();
    bus.out_ready = 1'b1;
    bus.res_valid = 1'b1;
    set_lanes(16'hDEAD, 16'hBEEF, 16'hDEAD, 16'hBEEF);
    step();
    step();
    bus.res_valid = 1'b0;
    wait_done("ovr_done", 100, 0);
    chk("ovr_sticky", bus.res_overrun, 1);
    step();

    // Reset after 10 words of a drain
    capture_random();
    bus.out_ready = 1'b1;
    start = hs_total;
    n = 0;
    while (hs_total - start < 10 && n < 100) begin
      step();
      n++;
    end
    chk("mid_drain_words", hs_total - start, 10);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mrst_out_valid",   bus.out_valid,   0);
    chk("mrst_cap_ready",   bus.cap_ready,   1);
    chk("mrst_res_overrun", bus.res_overrun, 0);
    chk("mrst_out_last",    bus.out_last,    0);
    chk("mrst_unload_done", bus.unload_done, 0);

    // Fresh capture after reset; first two words 0007 and 0003
    bus.out_ready = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      bus.res_valid = 1'b1;
      if (e == 0) set_lanes(16'h0007, 16'h0003, 16'h00F0, 16'h0001);
      else set_lanes(RES_W'($urandom), RES_W'($urandom), RES_W'($urandom), RES_W'($urandom));
      step();
    end
    bus.res_valid = 1'b0;
    chk("fresh_word0", bus.out_data, 16'h0007);
`ifdef Y_PARITY_EN
    chk("parity_0007", bus.out_parity, 1);
`endif
    step();
    chk("stall_hold", bus.out_data, 16'h0007);
    bus.out_ready = 1'b1;
    step();
    chk("fresh_word1", bus.out_data, 16'h0003);
`ifdef Y_PARITY_EN
    chk("parity_0003", bus.out_parity, 0);
`endif
    wait_done("fresh_done", 100, 0);
    step();

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      bus.res_valid = ($urandom_range(0, 3) != 0);
      set_lanes(RES_W'($urandom), RES_W'($urandom), RES_W'($urandom), RES_W'($urandom));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 499) == 0) rst = 1'b0;
      else rst = 1'b1;
      step();
    end
    rst = 1'b1;
    bus.res_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
